ms_timer_arbiter: RTL and testbench

//   Shares one millisecond interval timer among N_REQ requesters. Each requester

---
 rtl/ms_timer_arbiter.sv | 144 ++++++++++++++
 tb/tb_ms_timer_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_timer_arbiter.sv
// Shared millisecond interval timer with round-robin arbitration among N_REQ requesters.
// The owner's ms_len is counted in TICKS_PER_MS-cycle units, then a one-cycle done pulse is issued.
module ms_timer_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MS_W         = 8,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned TICKS_PER_MS = 16'h82C7
) (
  input  logic                    tick,
  input  logic                    clear,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*MS_W-1:0]   ms_len,
  input  logic                    abort,
  output logic                    busy,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [MS_W-1:0]         ms_left
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [MS_W-1:0]    ms_left_q, ms_left_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               busy_q, busy_d;

  logic [MS_W-1:0]    len_arr [N_REQ];
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      len_arr[i] = ms_len[i*MS_W +: MS_W];
    end
  end

  // Scan starts just after the previous owner, so it becomes last in line.
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cidx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(last_q) + 32'd1 + k) % N_REQ;
      cidx = IDX_W'(cand);
      if (!win_found && req[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ms_left_d  = ms_left_q;
    tick_cnt_d = tick_cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    case (state_q)
      S_IDLE: begin
        grant_d    = '0;
        ms_left_d  = '0;
        tick_cnt_d = '0;
        if (!abort && win_found) begin
          owner_d          = win_idx;
          grant_d[win_idx] = 1'b1;
          ms_left_d        = len_arr[win_idx];
          state_d          = (len_arr[win_idx] == '0) ? S_DONE : S_COUNT;
        end
      end
      S_COUNT: begin
        if (abort) begin
          state_d    = S_IDLE;
          grant_d    = '0;
          ms_left_d  = '0;
          tick_cnt_d = '0;
          last_d     = owner_q;
        end else if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          ms_left_d  = ms_left_q - MS_W'(1);
          if (ms_left_q == MS_W'(1)) begin
            state_d = S_DONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        grant_d    = '0;
        ms_left_d  = '0;
        tick_cnt_d = '0;
        last_d     = owner_q;
      end
      default: begin
        state_d    = S_IDLE;
        grant_d    = '0;
        ms_left_d  = '0;
        tick_cnt_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge tick) begin
    if (clear) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ms_left_q  <= '0;
      tick_cnt_q <= '0;
      last_q     <= IDX_W'(N_REQ - 1);
      owner_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ms_left_q  <= ms_left_d;
      tick_cnt_q <= tick_cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    done = (state_q == S_DONE) ? grant_q : '0;
  end

  assign busy    = busy_q;
  assign grant   = grant_q;
  assign ms_left = ms_left_q;

endmodule

// File: tb/tb_ms_timer_arbiter.sv
// Bench for ms_timer_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (owner, start cycle, length) evaluated with plain arithmetic.
module tb_ms_timer_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 4;

  logic          tick = 1'b0;
  logic          clear;
  logic          abort;
  logic [N-1:0]  req;
  logic [W-1:0]  lens [N];
  logic [N*W-1:0] ms_len;
  logic          busy;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic [W-1:0]  ms_left;

  assign ms_len = {lens[3], lens[2], lens[1], lens[0]};

  always #5 tick = ~tick;

  ms_timer_arbiter #(
    .N_REQ(N),
    .MS_W(W),
    .CNT_W(16),
    .TICKS_PER_MS(T)
  ) dut (
    .tick(tick),
    .clear(clear),
    .req(req),
    .ms_len(ms_len),
    .abort(abort),
    .busy(busy),
    .grant(grant),
    .done(done),
    .ms_left(ms_left)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = -1;
  int done_pulses = 0;

  // Model: one active transaction described by owner, grant cycle and length.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_start = 0;
  int m_len = 0;
  int m_last = N - 1;

  task automatic check_cycle();
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    logic [W-1:0] el;
    logic         eb;
    int           e;
    eg = '0;
    ed = '0;
    el = '0;
    eb = 1'b0;
    if (m_busy) begin
      e  = cyc - m_start;
      eg = 4'(1 << m_owner);
      eb = 1'b1;
      if (e == m_len * T) ed = eg;
      else el = 8'(m_len - e / T);
    end
    if (done != '0) begin
      last_done_cyc = cyc;
      done_pulses++;
    end
    checks++;
    assert (grant === eg) else begin
      errors++;
      $error("FAIL grant cyc=%0d observed=%b expected=%b", cyc, grant, eg);
    end
    checks++;
    assert (done === ed) else begin
      errors++;
      $error("FAIL done cyc=%0d observed=%b expected=%b", cyc, done, ed);
    end
    checks++;
    assert (busy === eb) else begin
      errors++;
      $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, eb);
    end
    checks++;
    assert (ms_left === el) else begin
      errors++;
      $error("FAIL ms_left cyc=%0d observed=%0d expected=%0d", cyc, ms_left, el);
    end
  endtask

  // Check the current cycle, then advance the model and the DUT by one edge.
  task automatic step();
    int  e;
    int  w;
    bit  found;
    @(negedge tick);
    check_cycle();
    if (clear) begin
      m_busy = 1'b0;
      m_last = N - 1;
    end else if (!m_busy) begin
      if (!abort && req != '0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          w = (m_last + k) % N;
          if (!found && ((req >> w) & 4'd1) != 4'd0) begin
            found   = 1'b1;
            m_owner = w;
          end
        end
        m_busy  = 1'b1;
        m_start = cyc + 1;
        m_len   = int'(lens[m_owner]);
      end
    end else begin
      e = cyc - m_start;
      if (abort || e == m_len * T) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
    @(posedge tick);
    #1;
    cyc++;
  endtask

  task automatic idle_for(input int n);
    req   = '0;
    abort = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  int t0;

  initial begin
    clear = 1'b1;
    abort = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) lens[i] = '0;
    repeat (2) @(posedge tick);
    #1;
    // Reset state observed while clear is still asserted.
    step();
    clear = 1'b0;

    // 1: single request, 3 ms; done expected 13 cycles after the request.
    lens[0] = 8'd3;
    req     = 4'b0001;
    t0      = cyc;
    last_done_cyc = -1;
    step();
    req = '0;
    for (int i = 0; i < 16; i++) step();
    checks++;
    assert (last_done_cyc - t0 == 13) else begin
      errors++;
      $error("FAIL t1_done_cycle observed=%0d expected=%0d", last_done_cyc - t0, 13);
    end

    // 2: all requesting with 1 ms each; rotation checked by the model.
    for (int i = 0; i < N; i++) lens[i] = 8'd1;
    done_pulses = 0;
    req = 4'b1111;
    for (int i = 0; i < 26; i++) step();
    idle_for(6);
    checks++;
    assert (done_pulses == 5) else begin
      errors++;
      $error("FAIL t2_done_pulses observed=%0d expected=%0d", done_pulses, 5);
    end

    // 3: zero-length request goes straight to the done cycle.
    lens[2] = 8'd0;
    req     = 4'b0100;
    step();
    idle_for(4);

    // 4: abort during requester 0's timing; requester 1 goes next.
    lens[0] = 8'd3;
    lens[1] = 8'd3;
    req     = 4'b0011;
    for (int i = 0; i < 5; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    req   = 4'b0011;
    for (int i = 0; i < 3; i++) step();
    req = '0;
    idle_for(14);

    // 5: clear mid-count, then restart.
    lens[0] = 8'd5;
    req     = 4'b0001;
    for (int i = 0; i < 7; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    lens[0] = 8'd2;
    step();
    req = '0;
    idle_for(12);

    // 6: ms_len and req change during COUNT are ignored.
    lens[0] = 8'd2;
    req     = 4'b0001;
    t0      = cyc;
    step();
    req = '0;
    step();
    step();
    lens[0] = 8'd9;
    for (int i = 0; i < 10; i++) step();
    checks++;
    assert (last_done_cyc - t0 == 9) else begin
      errors++;
      $error("FAIL t6_done_cycle observed=%0d expected=%0d", last_done_cyc - t0, 9);
    end
    idle_for(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      req   = 4'($urandom_range(0, 15));
      for (int j = 0; j < N; j++) lens[j] = 8'($urandom_range(0, 3));
      abort = ($urandom_range(0, 15) == 0);
      clear = ($urandom_range(0, 99) == 0);
      step();
    end
    idle_for(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
